// File: rtl/selector_pkg.sv
// ============================================================================
// Module      : selector_pkg
// Description : Shared types and defaults for the 1:2 output selector path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package selector_pkg;

    localparam int DATA_W        = 32;
    localparam int DEFAULT_DEPTH = 4;

    // Encoding matches the selector's OPTION_0 / OPTION_1 select values.
    typedef enum logic {
        DEST_0 = 1'b0,
        DEST_1 = 1'b1
    } dest_t;

    typedef struct packed {
        dest_t             dest;
        logic [DATA_W-1:0] data;
    } route_entry_t;

endpackage

`default_nettype wire

// File: rtl/selector_feed_mem.sv
// ============================================================================
// Module      : selector_feed_mem
// Description : Entry storage for selector_feed; sync write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module selector_feed_mem #(
    parameter int ENTRY_W = 33,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [ENTRY_W-1:0]       i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [ENTRY_W-1:0]       o_rdata
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    // Contents are don't-care after reset; COUNT gates every use of them.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/selector_feed.sv
// ============================================================================
// Module      : selector_feed
// Description : FIFO feeding the 1:2 selector with per-destination handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module selector_feed
    import selector_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_dest,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     select,
    output logic [WIDTH-1:0]         data_out,
    output logic                     out_valid_0,
    output logic                     out_valid_1,
    input  logic                     out_ready_0,
    input  logic                     out_ready_1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                c_PTR_W     = $clog2(DEPTH);
    localparam int                c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [WIDTH:0]     w_head;
    dest_t              w_head_dest;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    selector_feed_mem #(
        .ENTRY_W (WIDTH + 1),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push && !flush),
        .i_waddr (r_wr_ptr),
        .i_wdata ({in_dest, in_data}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    assign w_empty     = (r_count == '0);
    assign w_head_dest = dest_t'(w_head[WIDTH]);

    // Ready depends on registered COUNT only, so consumers never loop back to the producer.
    assign in_ready    = (r_count < c_DEPTH_CNT);
    assign out_valid_0 = !w_empty && (w_head_dest == DEST_0);
    assign out_valid_1 = !w_empty && (w_head_dest == DEST_1);
    assign select      = w_empty ? 1'b0 : w_head[WIDTH];
    assign data_out    = w_empty ? '0 : w_head[WIDTH-1:0];
    assign count       = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = (out_valid_0 && out_ready_0) || (out_valid_1 && out_ready_1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
